// File: rtl/sr_latch_bank.sv
// Clocked bank of WIDTH active-low SR cells with sticky change flags and a registered popcount.
// Optional build macro SR_LATCH_BANK_TOGGLE_EN: both inputs low toggles the cell (JK behaviour).
module sr_latch_bank #(
    parameter int                 WIDTH        = 8,
    parameter int                 SET_PRIORITY = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL    = '0,
    localparam int                CNT_W        = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   s_n,
    input  logic [WIDTH-1:0]   r_n,
    input  logic               clr_changed,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qn,
    output logic [WIDTH-1:0]   changed,
    output logic [CNT_W-1:0]   ones_cnt,
    output logic               any_set
);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] changed_next;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic both_low_value(input logic cur);
`ifdef SR_LATCH_BANK_TOGGLE_EN
        return ~cur;
`else
        return (SET_PRIORITY != 0) ? 1'b1 : cur & 1'b0;
`endif
    endfunction

    always_comb begin
        q_next = q;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({s_n[i], r_n[i]})
                    2'b01:   q_next[i] = 1'b1;
                    2'b10:   q_next[i] = 1'b0;
                    2'b00:   q_next[i] = both_low_value(q[i]);
                    default: q_next[i] = q[i];
                endcase
            end
        end
    end

    // A change on the same edge as a clear wins, so no event is lost.
    always_comb begin
        changed_next = (q_next ^ q) | (clr_changed ? '0 : changed);
    end

    // Stage boundary: every output is registered; statistics come from next-state q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= RESET_VAL;
            qn       <= ~RESET_VAL;
            changed  <= '0;
            ones_cnt <= popcount(RESET_VAL);
            any_set  <= |RESET_VAL;
        end else begin
            q        <= q_next;
            qn       <= ~q_next;
            changed  <= changed_next;
            ones_cnt <= popcount(q_next);
            any_set  <= |q_next;
        end
    end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Bench for sr_latch_bank: two instances (set-priority/RESET_VAL=A5 and reset-priority/RESET_VAL=00)
// share stimulus and are checked every cycle against a behavioural model, plus literal anchor checks.
module tb_sr_latch_bank;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic         clk = 1'b0;
    logic         rst, en, clr;
    logic [W-1:0] s_n, r_n;

    logic [W-1:0]  qa, qna, cha;
    logic [CW-1:0] cnta;
    logic          anya;
    logic [W-1:0]  qb, qnb, chb;
    logic [CW-1:0] cntb;
    logic          anyb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sr_latch_bank #(.WIDTH(W), .SET_PRIORITY(1), .RESET_VAL(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .en(en), .s_n(s_n), .r_n(r_n), .clr_changed(clr),
        .q(qa), .qn(qna), .changed(cha), .ones_cnt(cnta), .any_set(anya));

    sr_latch_bank #(.WIDTH(W), .SET_PRIORITY(0), .RESET_VAL(8'h00)) dut_b (
        .clk(clk), .rst(rst), .en(en), .s_n(s_n), .r_n(r_n), .clr_changed(clr),
        .q(qb), .qn(qnb), .changed(chb), .ones_cnt(cntb), .any_set(anyb));

    // Reference state: a cell value and a sticky flag per bit, per instance.
    bit ma[W], mb[W], fa[W], fb[W];
    bit model_ok = 1'b0;

    function automatic bit cell_next(bit cur, bit s, bit r, bit prio, bit e);
        if (!e) return cur;
        if (s && r) begin
`ifdef SR_LATCH_BANK_TOGGLE_EN
            return !cur;
`else
            return prio;
`endif
        end
        if (s) return 1'b1;
        if (r) return 1'b0;
        return cur;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            bit na, nb;
            if (rst) begin
                ma[i] = (8'hA5 >> i) & 1;
                mb[i] = 1'b0;
                fa[i] = 1'b0;
                fb[i] = 1'b0;
            end else begin
                na = cell_next(ma[i], !s_n[i], !r_n[i], 1'b1, en);
                nb = cell_next(mb[i], !s_n[i], !r_n[i], 1'b0, en);
                fa[i] = (na != ma[i]) ? 1'b1 : (clr ? 1'b0 : fa[i]);
                fb[i] = (nb != mb[i]) ? 1'b1 : (clr ? 1'b0 : fb[i]);
                ma[i] = na;
                mb[i] = nb;
            end
        end
        if (rst) model_ok = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack(input bit v[W]);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[i];
        return r;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            logic [W-1:0] eqa, eqb;
            eqa = pack(ma);
            eqb = pack(mb);
            chk("a_q",   {24'b0, qa},  {24'b0, eqa});
            chk("a_qn",  {24'b0, qna}, {24'b0, ~eqa});
            chk("a_chg", {24'b0, cha}, {24'b0, pack(fa)});
            chk("a_cnt", 32'(cnta),    32'($countones(eqa)));
            chk("a_any", 32'(anya),    32'(eqa != 0));
            chk("b_q",   {24'b0, qb},  {24'b0, eqb});
            chk("b_qn",  {24'b0, qnb}, {24'b0, ~eqb});
            chk("b_chg", {24'b0, chb}, {24'b0, pack(fb)});
            chk("b_cnt", 32'(cntb),    32'($countones(eqb)));
            chk("b_any", 32'(anyb),    32'(eqb != 0));
        end
    end

    task automatic step(input logic r, input logic e, input logic [W-1:0] s, input logic [W-1:0] rr,
                        input logic c);
        rst = r; en = e; s_n = s; r_n = rr; clr = c;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; s_n = '1; r_n = '1; clr = 1'b0;
        @(negedge clk);

        // Reset to programmable value, then a set request coinciding with reset is discarded.
        step(1, 1, 8'hFF, 8'hFF, 0);
        chk("rst_q", {24'b0, qa}, 32'hA5);
        chk("rst_qn", {24'b0, qna}, 32'h5A);
        chk("rst_chg", {24'b0, cha}, 32'h00);
        chk("rst_cnt", 32'(cnta), 32'd4);
        chk("rst_any", 32'(anya), 32'd1);
        chk("rst_b_any", 32'(anyb), 32'd0);
        step(1, 1, 8'h00, 8'hFF, 0);
        chk("rst_discard_q", {24'b0, qa}, 32'hA5);
        step(0, 1, 8'h00, 8'hFF, 0);
        chk("post_rst_q", {24'b0, qa}, 32'hFF);
        chk("post_rst_chg", {24'b0, cha}, 32'h5A);

        // Set / reset / hold.
        step(0, 1, 8'hFF, 8'h00, 0);
        step(0, 1, 8'hF0, 8'hFF, 0);
        chk("set_q", {24'b0, qa}, 32'h0F);
        chk("set_cnt", 32'(cnta), 32'd4);
        step(0, 1, 8'hFF, 8'hFE, 0);
        chk("reset_q", {24'b0, qa}, 32'h0E);
        chk("reset_cnt", 32'(cnta), 32'd3);
        for (int k = 0; k < 3; k++) step(0, 1, 8'hFF, 8'hFF, 0);
        chk("hold_q", {24'b0, qa}, 32'h0E);

`ifndef SR_LATCH_BANK_TOGGLE_EN
        // Both inputs asserted: priority decides.
        step(0, 1, 8'h00, 8'h00, 0);
        chk("prio_set_q", {24'b0, qa}, 32'hFF);
        chk("prio_rst_q", {24'b0, qb}, 32'h00);
        chk("prio_cnt", 32'(cnta), 32'd8);
`endif

        // Enable gating, then sticky flags.
        step(0, 1, 8'hFF, 8'h00, 0);
        step(0, 1, 8'hC3, 8'hFF, 0);
        step(0, 1, 8'hFF, 8'hFF, 1);
        chk("en_pre_q", {24'b0, qa}, 32'h3C);
        chk("en_pre_chg", {24'b0, cha}, 32'h00);
        step(0, 0, 8'h00, 8'hFF, 0);
        chk("en0_q", {24'b0, qa}, 32'h3C);
        chk("en0_chg", {24'b0, cha}, 32'h00);
        step(0, 1, 8'h00, 8'hFF, 0);
        chk("en1_q", {24'b0, qa}, 32'hFF);
        chk("en1_chg", {24'b0, cha}, 32'hC3);
        step(0, 1, 8'hFF, 8'hFE, 1);
        chk("clr_change_chg", {24'b0, cha}, 32'h01);
        step(0, 0, 8'hFF, 8'hFF, 1);
        chk("clr_en0_chg", {24'b0, cha}, 32'h00);

`ifdef SR_LATCH_BANK_TOGGLE_EN
        step(0, 1, 8'hFF, 8'h00, 0);
        step(0, 1, 8'hF0, 8'hFF, 1);
        step(0, 1, 8'h00, 8'h00, 1);
        chk("tog1_q", {24'b0, qa}, 32'hF0);
        chk("tog1_chg", {24'b0, cha}, 32'hFF);
        chk("tog1_cnt", 32'(cnta), 32'd4);
        step(0, 1, 8'h00, 8'h00, 0);
        chk("tog2_q", {24'b0, qa}, 32'h0F);
        chk("tog2_cnt", 32'(cnta), 32'd4);
`endif

        // All-ones boundary for ones_cnt.
        step(0, 1, 8'h00, 8'hFF, 0);
        chk("full_cnt", 32'(cnta), 32'd8);

        // Randomized traffic; the model checks every cycle.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 W'($urandom), W'($urandom), ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
